// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Multi-cycle unsigned shift-and-add multiplier controller. It
//            borrows the shared execute-stage ALU adder once per iteration
//            and produces MUL (low word) or MULHU (high word) results.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            start, op, a, b       - request, MUL/MULHU select, operands
//            flush                 - abort the operation in flight
//            busy, done, result    - stall request, completion pulse, product
//            alu_a, alu_b, alu_sel - drive to the external ALU
//            alu_result, alu_carry - sum and carry back from the ALU
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int         N       = 32,
    parameter logic [3:0] ADD_SEL = 4'b0010,
    parameter int         CNT_W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    input  logic         alu_carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_hi;
    logic [N-1:0]     r_lo;
    logic [CNT_W-1:0] r_count;
    logic             r_op;

    logic [N-1:0]     w_hi_next;
    logic [N-1:0]     w_lo_next;
    logic             w_last;
    logic             w_zero;

    // The ALU is only used while iterating; outside RUN it sees a quiet ADD
    // of zeros so its outputs do not toggle needlessly.
    always_comb begin
        alu_sel = ADD_SEL;
        alu_a   = '0;
        alu_b   = '0;
        if (r_state == S_RUN) begin
            alu_a = r_hi;
            alu_b = r_lo[0] ? r_mcand : '0;
        end
    end

    // The (N+1)-bit partial sum {carry, alu_result} is shifted right by one
    // into {hi, lo}. When no add was performed the carry is forced to zero.
    assign w_hi_next = {alu_carry & r_lo[0], alu_result[N-1:1]};
    assign w_lo_next = {alu_result[0], r_lo[N-1:1]};
    assign w_last    = (r_count == CNT_W'(N - 1));
    assign w_zero    = (a == '0) || (b == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_count <= '0;
            r_op    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (start) begin
                        r_mcand <= a;
                        r_lo    <= b;
                        r_hi    <= '0;
                        r_count <= '0;
                        r_op    <= op;
                        if (w_zero) begin
                            // Product is trivially zero; skip the iterations.
                            r_state <= S_DONE;
                            result  <= '0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            busy    <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (flush) begin
                        // Abort: result keeps the last completed product.
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        r_hi    <= w_hi_next;
                        r_lo    <= w_lo_next;
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= r_op ? w_hi_next : w_lo_next;
                        end else begin
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Purpose  : Self-checking bench for alu_mul_sequencer with an external
//            adder model and a plain-arithmetic product reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

    localparam int         N       = 32;
    localparam logic [3:0] ADD_SEL = 4'b0010;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_result;
    logic         alu_carry;

    int tests = 0;
    int fails = 0;
    logic [N-1:0] last_result;

    always #5 clk = ~clk;

    // Shared execute-stage ALU, ADD function only.
    assign {alu_carry, alu_result} = (alu_sel == ADD_SEL) ?
                                     ({1'b0, alu_a} + {1'b0, alu_b}) : '0;

    alu_mul_sequencer #(.N(N), .ADD_SEL(ADD_SEL), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] x,
                                             input logic [N-1:0] y,
                                             input logic         hi_sel);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        return hi_sel ? p[2*N-1:N] : p[N-1:0];
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs,
                         input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request; returns #1 after the accepting edge (cycle 1).
    task automatic go(input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic hi_sel);
        start = 1'b1;
        a     = x;
        b     = y;
        op    = hi_sel;
        tick();
        start = 1'b0;
    endtask

    // Walks cycles 1..lat; returns inside the done cycle (cycle lat).
    // With noise set, random start requests and operands are thrown at the
    // DUT while it iterates; they must be ignored.
    task automatic expect_op(input string tag, input logic [N-1:0] exp,
                             input int lat, input bit noise);
        for (int cyc = 1; cyc < lat; cyc++) begin
            check({tag, " busy"}, N'(busy), N'(1));
            check({tag, " early done"}, N'(done), N'(0));
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a     = $urandom;
                b     = $urandom;
                op    = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        check({tag, " done"}, N'(done), N'(1));
        check({tag, " busy at done"}, N'(busy), N'(0));
        check({tag, " result"}, result, exp);
        check({tag, " alu_a idle"}, alu_a, '0);
        check({tag, " alu_sel"}, N'(alu_sel), N'(ADD_SEL));
        last_result = exp;
    endtask

    task automatic settle(input string tag);
        tick();
        check({tag, " done pulse end"}, N'(done), N'(0));
        check({tag, " busy idle"}, N'(busy), N'(0));
    endtask

    initial begin
        logic [N-1:0] ra, rb, ex;
        logic         rop;

        // Reset held with start asserted: nothing may begin.
        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 1'b0;
        a = 32'd5; b = 32'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst busy", N'(busy), N'(0));
            check("rst done", N'(done), N'(0));
            check("rst result", result, '0);
            check("rst alu_sel", N'(alu_sel), N'(ADD_SEL));
            check("rst alu_b", alu_b, '0);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        check("post-rst busy", N'(busy), N'(0));
        check("post-rst done", N'(done), N'(0));
        last_result = '0;

        // Directed products.
        go(32'd7, 32'd6, 1'b0);
        expect_op("mul 7x6", 32'h0000002A, 33, 1'b0);
        settle("mul 7x6");

        go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        expect_op("mulhu ff", 32'hFFFFFFFE, 33, 1'b0);
        settle("mulhu ff");

        go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        expect_op("mul ff", 32'h00000001, 33, 1'b0);
        settle("mul ff");

        // Zero shortcut.
        go(32'd0, 32'h1234, 1'b0);
        expect_op("zero", 32'd0, 1, 1'b0);
        settle("zero");

        // Flush mid-run: no done, result unchanged.
        go(32'd42, 32'd3, 1'b0);
        expect_op("pre-flush", 32'd126, 33, 1'b0);
        settle("pre-flush");
        go(32'd5, 32'd9, 1'b0);
        for (int cyc = 1; cyc < 10; cyc++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", N'(busy), N'(0));
        check("flush done", N'(done), N'(0));
        check("flush result", result, last_result);
        for (int i = 0; i < 35; i++) begin
            tick();
            check("flush no done", N'(done), N'(0));
        end
        check("flush result held", result, last_result);

        // start pulses during RUN are ignored.
        go(32'h00012345, 32'h00ABCDEF, 1'b1);
        expect_op("run noise", ref_mul(32'h00012345, 32'h00ABCDEF, 1'b1), 33, 1'b1);
        settle("run noise");

        // Back-to-back: second request presented in the done cycle.
        go(32'd3, 32'd4, 1'b0);
        expect_op("b2b first", 32'd12, 33, 1'b0);
        go(32'h00010000, 32'h00010000, 1'b1);
        expect_op("b2b second", 32'h00000001, 33, 1'b0);
        settle("b2b second");

        // flush together with start in DONE: flush wins.
        go(32'd11, 32'd13, 1'b0);
        expect_op("done flush", 32'd143, 33, 1'b0);
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("done flush busy", N'(busy), N'(0));
        check("done flush done", N'(done), N'(0));
        tick();
        check("done flush stays idle", N'(busy), N'(0));

        // Reset in the middle of an operation.
        go(32'd100, 32'd200, 1'b0);
        for (int cyc = 1; cyc < 6; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", N'(busy), N'(0));
        check("midrst done", N'(done), N'(0));
        check("midrst result", result, '0);
        last_result = '0;

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) ra = '0;
            if ($urandom_range(0, 5) == 0) rb = '0;
            rop = 1'($urandom_range(0, 1));
            ex  = ref_mul(ra, rb, rop);
            go(ra, rb, rop);
            expect_op("random", ex, ((ra == '0) || (rb == '0)) ? 1 : 33,
                      1'($urandom_range(0, 1)));
            settle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle unsigned shift-and-add multiplier controller for the RV32 execute stage. It reuses the shared NBitALU adder (ADD select) once per iteration instead of instantiating a dedicated multiplier. It produces MUL (low word) or MULHU (high word) results, and asserts busy so the pipeline can stall the execute stage. The ALU itself is instantiated outside this block; this block only drives its operand and select inputs and consumes its result and carry.

Parameters:
N, 32, operand/result width; iteration count equals N
ADD_SEL, 4'b0010, ALU select code for ADD
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > N

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; sampled in IDLE or DONE only
op  in  1  0 = MUL (low N bits), 1 = MULHU (high N bits); captured with start
a  in  N  multiplicand; captured with start
b  in  N  multiplier; captured with start
flush  in  1  abort current operation (pipeline flush)
busy  out  1  high while state = RUN
done  out  1  one-cycle pulse: result valid
result  out  N  registered product word; holds until next completion
alu_a  out  N  ALU operand A
alu_b  out  N  ALU operand B
alu_sel  out  4  ALU select
alu_result  in  N  ALU result (combinational from alu_a/alu_b)
alu_carry  in  1  ALU carry_flag

Behaviour:
- States: IDLE, RUN, DONE. On reset: state = IDLE; busy, done = 0; result, hi, lo, mcand, count, op_q = 0.
- Internal registers: mcand[N], hi[N], lo[N], count[CNT_W], op_q.
- IDLE or DONE with start = 1 and flush = 0:
  - mcand <= a, lo <= b, hi <= 0, count <= 0, op_q <= op.
  - If a == 0 or b == 0 (zero shortcut), go to DONE with result <= 0.
  - Otherwise go to RUN.
- IDLE with start = 0: stay in IDLE. DONE with start = 0: go to IDLE.
- RUN, each cycle:
  - alu_a = hi, alu_b = lo[0] ? mcand : 0, alu_sel = ADD_SEL.
  - hi <= {alu_carry & lo[0], alu_result[N-1:1]}.
  - lo <= {alu_result[0], lo[N-1:1]}.
  - count <= count + 1.
- RUN exit: when count == N-1, after that cycle's update go to DONE and load result from the updated registers: result <= op_q ? new hi : new lo.
- Outputs in DONE: done = 1 for exactly that cycle; busy = 0.
- Latency: start edge, then N RUN cycles, then done in cycle N+1 after the start-accept edge. Zero shortcut: done in cycle 1.
- ALU drive outside RUN: alu_a = 0, alu_b = 0, alu_sel = ADD_SEL.
- start during RUN: ignored (no queueing).
- start during DONE: accepted, giving back-to-back operation. done still pulses this cycle, and the new operation begins.
- flush has priority over start in every state:
  - Next state is IDLE.
  - done is not asserted for the aborted operation.
  - result keeps its previous value; the hi/lo contents are don't-care.
- flush in DONE: done is still high that cycle (already committed), then IDLE.
- rst overrides everything; mid-operation reset returns to IDLE with all outputs 0.
- Arithmetic is unsigned only. The {hi,lo} pair equals the full 2N-bit product after N iterations.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with start = 1 -> busy = 0, done = 0, result = 0, alu_sel = 4'b0010; no operation starts.
- MUL 7 × 6: start with op = 0 -> busy is high cycles 1–32, done pulses in cycle 33, result = 0x0000002A; busy drops to 0 the same cycle.
- 0xFFFFFFFF × 0xFFFFFFFF: with op = 1 -> result = 0xFFFFFFFE; repeated with op = 0 -> result = 0x00000001 (checks carry propagation into hi).
- Zero shortcut: a = 0, b = 0x1234 -> done in cycle 1, result = 0, busy never asserted.
- Flush: start 5 × 9, then flush at RUN cycle 10 -> IDLE next cycle, no done pulse, result unchanged.
  - start pulses during RUN in a separate run are ignored; the original operation's result is unaffected.
- Back-to-back: start 3 × 4 (op = 0), then start 0x10000 × 0x10000 (op = 1) in the done cycle:
  - first result = 12, done pulses once;
  - second done arrives 33 cycles later with result = 0x00000001.
